line_bank_read_scheduler: RTL and testbench
===========================================

# line_bank_read_scheduler

Read-side controller for the dual-bank line FIFO array (bank 0 = lines 0..L-1, bank 1 = lines L..2L-1) in the pixel-clock domain. It grants a bank that is full, arbitrating round-robin when both are full. It walks the bank's lines one-hot and produces per-line read strobes plus AXI4-Stream framing (valid, last, sof, frame end). It sits between the FWFT line FIFOs/data mux and the downstream video AXI4-Stream sink.

## Interface
- LINES_PER_BANK, 12, lines per bank (L); total lines 2L
- H_ACTIVE, 1920, beats per line
- V_ACTIVE, 1080, lines per frame
- CNT_W, 12, h/v counter width; must satisfy 2^CNT_W > max(H_ACTIVE, V_ACTIVE)

Ports:
- i_pclk  in  1  pixel clock
- i_rst  in  1  synchronous, active-high reset (clock i_pclk)
- i_bank_full  in  2  per-bank full level, already synchronized to i_pclk
- i_line_empty  in  2L  per-line FIFO empty
- i_sof_pulse  in  1  one-cycle frame-start request, i_pclk domain
- i_m_axis_ready  in  1  sink ready
- o_line_sel  out  2L  one-hot selected line (drives the external data mux); 0 when idle
- o_line_rd_en  out  2L  o_line_sel & {2L{o_m_axis_valid & i_m_axis_ready}}
- o_m_axis_valid  out  1  beat valid
- o_m_axis_last  out  1  last beat of line
- o_m_axis_sof  out  1  tuser start-of-frame
- o_frame_end  out  1  one-cycle pulse after final beat of line V_ACTIVE-1
- o_bank_done  out  2  one-cycle pulse when a bank is fully drained
- o_underflow  out  1  sticky: selected line empty while active

## Operation
- FSM states: IDLE, STREAM, RELEASE.
- IDLE: o_line_sel=0. A bank is eligible if i_bank_full[b] & rearm[b].
  - One eligible bank: grant it.
  - Both eligible: grant !last_bank.
  - On grant: o_line_sel <= one-hot of line b*L, line_idx <= 0, h <= 0, state STREAM.
- STREAM:
  - active = 1; o_m_axis_valid = active & ~|(i_line_empty & o_line_sel).
  - A beat is valid & ready; each beat increments h.
  - Beat with h==H_ACTIVE-1: h <= 0 and v <= (v==V_ACTIVE-1) ? 0 : v+1.
  - On that beat, if line_idx < L-1: o_line_sel <<= 1 and line_idx++. There is no bubble between lines.
  - Otherwise go to RELEASE.
- RELEASE (one cycle): o_line_sel=0, valid=0, o_bank_done[b]=1, last_bank <= b, rearm[b] <= 0, then IDLE.
- Rearm: rearm[b] <= 1 on any cycle with i_bank_full[b]==0. This blocks re-granting a bank whose full flag has not yet dropped through CDC lag.
- o_m_axis_last = o_m_axis_valid & (h==H_ACTIVE-1).
- SOF:
  - i_sof_pulse sets sof_armed.
  - o_m_axis_sof = o_m_axis_valid & h==0 & v==0 & sof_armed; sof_armed clears on that beat.
  - If the pulse arrives with v!=0, v is forced to 0 at the next line start (h==0 boundary), so the next line carries sof (frame resync).
- o_frame_end: registered, asserted the cycle after the last beat of line V_ACTIVE-1.
- Underflow: active with the selected line empty sets o_underflow (sticky until reset). Valid drops while empty. Banks are granted only when full, so this indicates an upstream fault.
- Arithmetic: h, v unsigned CNT_W; wrap exactly as above, never past H_ACTIVE-1 / V_ACTIVE-1.

## Timing
- Reset values: all outputs 0, state IDLE, h=v=0, last_bank=1 (bank 0 wins the first tie), rearm=2'b11, sof_armed=0.
- Grant latency: bank full sampled at edge N gives o_line_sel/o_m_axis_valid high from cycle N+1.
- Valid is held until ready; sel/h/v change only on beats (or the resync boundary).
- Drain time with continuous ready: L×H_ACTIVE beats, plus 1 RELEASE cycle and ≥1 IDLE cycle before the next grant.
- o_line_rd_en is combinational from registered state, i_line_empty and i_m_axis_ready (zero latency to FWFT pop).
- Reset mid-STREAM aborts the line immediately: no last or bank_done is emitted and the counters restart at 0.

## Structure
- Package line_buf_pkg: state enum (IDLE/STREAM/RELEASE), default LINES_PER_BANK/H_ACTIVE/V_ACTIVE constants, CNT_W.
- Sub-module axis_frame_counter: h/v counters, last/sof/frame_end generation and sof resync. Inputs: beat, line_start, sof_pulse.

## Test plan
- Bank 0 full, ready=1, L=12, H=1920: sel walks 0x000001→0x000800; last on beats 1919, 3839, …; o_bank_done=01 after 23040 beats.
- Both full in the same cycle after reset: bank 0 is granted; after release, bank 1 is granted (sel 0x001000); then round-robin resumes.
- Bank 0 full held high for 3 cycles after release: no re-grant until full is seen low and then high again.
- i_sof_pulse before the first grant: sof on beat 0 only. A pulse at v=500: the next line starts with v=0 and sof=1.
- Ready toggled 1/0 every cycle: data/sel stable while stalled; total beats per line exactly 1920.
- Selected line empty mid-line: valid drops and o_underflow=1 sticky; i_rst mid-line returns all outputs to 0 in the next cycle.

Source files
------------

// File: rtl/line_buf_pkg.sv
// +--------------------------------------------------------------------------+
// | line_buf_pkg: shared types and default geometry for the line-bank reader |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package line_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DEF_LINES_PER_BANK = 12;
    localparam int DEF_H_ACTIVE       = 1920;
    localparam int DEF_V_ACTIVE       = 1080;
    localparam int DEF_CNT_W          = 12;

endpackage

`default_nettype wire

// File: rtl/axis_frame_counter.sv
// +--------------------------------------------------------------------------+
// | axis_frame_counter: h/v beat counters, last/sof/frame_end, sof resync    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_frame_counter
    import line_buf_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic beat,
    input  logic line_start,
    input  logic sof_pulse,
    output logic line_end,
    output logic last,
    output logic sof,
    output logic frame_end
);

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             sof_armed;
    logic             resync;

    assign line_end = (h == H_MAX);
    assign last     = valid & line_end;
    assign sof      = valid & (h == '0) & (v == '0) & sof_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            h         <= '0;
            v         <= '0;
            sof_armed <= 1'b0;
            resync    <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= beat & line_end & (v == V_MAX);

            if (line_start) begin
                h <= '0;
                if (resync) begin
                    v      <= '0;
                    resync <= 1'b0;
                end
            end else if (beat) begin
                if (line_end) begin
                    h <= '0;
                    if (resync) begin
                        v      <= '0;
                        resync <= 1'b0;
                    end else if (v == V_MAX) begin
                        v <= '0;
                    end else begin
                        v <= v + CNT_W'(1);
                    end
                end else begin
                    h <= h + CNT_W'(1);
                end
            end else if (resync && (h == '0)) begin
                // Sitting on a line boundary: restart the frame before the next beat
                v      <= '0;
                resync <= 1'b0;
            end

            if (sof_pulse) begin
                sof_armed <= 1'b1;
                if (v != '0) begin
                    resync <= 1'b1;
                end
            end else if (beat && sof) begin
                sof_armed <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/line_bank_read_scheduler.sv
// +--------------------------------------------------------------------------+
// | line_bank_read_scheduler: round-robin bank grant, one-hot line walk, AXIS|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module line_bank_read_scheduler
    import line_buf_pkg::*;
#(
    parameter int LINES_PER_BANK = DEF_LINES_PER_BANK,
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int V_ACTIVE       = DEF_V_ACTIVE,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                        i_pclk,
    input  logic                        i_rst,
    input  logic [1:0]                  i_bank_full,
    input  logic [2*LINES_PER_BANK-1:0] i_line_empty,
    input  logic                        i_sof_pulse,
    input  logic                        i_m_axis_ready,
    output logic [2*LINES_PER_BANK-1:0] o_line_sel,
    output logic [2*LINES_PER_BANK-1:0] o_line_rd_en,
    output logic                        o_m_axis_valid,
    output logic                        o_m_axis_last,
    output logic                        o_m_axis_sof,
    output logic                        o_frame_end,
    output logic [1:0]                  o_bank_done,
    output logic                        o_underflow
);

    localparam int NL    = 2 * LINES_PER_BANK;
    localparam int IDX_W = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1;

    localparam logic [NL-1:0]    SEL_BANK0 = NL'(1);
    localparam logic [NL-1:0]    SEL_BANK1 = SEL_BANK0 << LINES_PER_BANK;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LINES_PER_BANK - 1);

    state_t           state;
    logic [NL-1:0]    line_sel;
    logic [IDX_W-1:0] line_idx;
    logic             bank;
    logic             last_bank;
    logic [1:0]       rearm;
    logic [1:0]       bank_done;
    logic             underflow;

    logic [1:0]       eligible;
    logic             grant;
    logic             grant_bank;
    logic             active;
    logic             sel_empty;
    logic             valid;
    logic             beat;
    logic             line_end;

    assign eligible   = i_bank_full & rearm;
    assign grant      = (state == IDLE) & (|eligible);
    // On a tie the bank not served last wins, so a tie after reset picks bank 0
    assign grant_bank = (eligible == 2'b11) ? ~last_bank : eligible[1];

    assign active    = (state == STREAM);
    assign sel_empty = |(i_line_empty & line_sel);
    assign valid     = active & ~sel_empty;
    assign beat      = valid & i_m_axis_ready;

    assign o_line_sel     = line_sel;
    assign o_line_rd_en   = line_sel & {NL{beat}};
    assign o_m_axis_valid = valid;
    assign o_bank_done    = bank_done;
    assign o_underflow    = underflow;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state     <= IDLE;
            line_sel  <= '0;
            line_idx  <= '0;
            bank      <= 1'b0;
            last_bank <= 1'b1;
            rearm     <= 2'b11;
            bank_done <= 2'b00;
            underflow <= 1'b0;
        end else begin
            bank_done <= 2'b00;

            case (state)
                IDLE: begin
                    if (grant) begin
                        bank     <= grant_bank;
                        line_sel <= grant_bank ? SEL_BANK1 : SEL_BANK0;
                        line_idx <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat && line_end) begin
                        if (line_idx == IDX_LAST) begin
                            line_sel        <= '0;
                            bank_done[bank] <= 1'b1;
                            state           <= RELEASE;
                        end else begin
                            line_sel <= line_sel << 1;
                            line_idx <= line_idx + IDX_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    last_bank   <= bank;
                    rearm[bank] <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A low full flag re-arms its bank; this overrides the release-time clear
            for (int b = 0; b < 2; b++) begin
                if (!i_bank_full[b]) begin
                    rearm[b] <= 1'b1;
                end
            end

            if (active && sel_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    axis_frame_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CNT_W    (CNT_W)
    ) u_frame_counter (
        .clk        (i_pclk),
        .rst        (i_rst),
        .valid      (valid),
        .beat       (beat),
        .line_start (grant),
        .sof_pulse  (i_sof_pulse),
        .line_end   (line_end),
        .last       (o_m_axis_last),
        .sof        (o_m_axis_sof),
        .frame_end  (o_frame_end)
    );

endmodule

`default_nettype wire

// File: tb/tb_line_bank_read_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_line_bank_read_scheduler: scoreboard bench with a frame-level model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_line_bank_read_scheduler;

    localparam int L   = 3;
    localparam int H   = 8;
    localparam int V   = 5;
    localparam int CW  = 4;
    localparam int NL  = 2 * L;
    localparam int NEP = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    bank_full;
    logic [NL-1:0] line_empty;
    logic          sof_pulse;
    logic          ready = 1'b0;
    logic [NL-1:0] line_sel;
    logic [NL-1:0] line_rd_en;
    logic          m_valid;
    logic          m_last;
    logic          m_sof;
    logic          frame_end;
    logic [1:0]    bank_done;
    logic          underflow;

    always #5 clk = ~clk;

    line_bank_read_scheduler #(
        .LINES_PER_BANK (L),
        .H_ACTIVE       (H),
        .V_ACTIVE       (V),
        .CNT_W          (CW)
    ) dut (
        .i_pclk         (clk),
        .i_rst          (rst),
        .i_bank_full    (bank_full),
        .i_line_empty   (line_empty),
        .i_sof_pulse    (sof_pulse),
        .i_m_axis_ready (ready),
        .o_line_sel     (line_sel),
        .o_line_rd_en   (line_rd_en),
        .o_m_axis_valid (m_valid),
        .o_m_axis_last  (m_last),
        .o_m_axis_sof   (m_sof),
        .o_frame_end    (frame_end),
        .o_bank_done    (bank_done),
        .o_underflow    (underflow)
    );

    typedef struct {
        int line;
        int bank;
        bit last;
        bit sof;
        bit fe;
        bit done;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    int    rdy_mode = 0;

    // Frame-level reference state
    int v_m = 0;
    bit armed_m = 1'b0;
    bit resync_m = 1'b0;
    int last_bank_m = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] onehot(input int idx);
        logic [NL-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    function automatic void model_sof();
        armed_m = 1'b1;
        if (v_m != 0) resync_m = 1'b1;
    endfunction

    function automatic void push_bank(input int b);
        beat_t e;
        for (int ln = 0; ln < L; ln++) begin
            if (resync_m) begin
                v_m      = 0;
                resync_m = 1'b0;
            end
            for (int hh = 0; hh < H; hh++) begin
                e.line = b * L + ln;
                e.bank = b;
                e.last = (hh == H - 1);
                e.sof  = armed_m && hh == 0 && v_m == 0;
                if (e.sof) armed_m = 1'b0;
                e.fe   = e.last && v_m == V - 1;
                e.done = e.last && ln == L - 1;
                exp_q.push_back(e);
            end
            v_m = (v_m == V - 1) ? 0 : v_m + 1;
        end
    endfunction

    // Ready generator: random, strict toggle, or held high
    initial begin
        forever begin
            @(negedge clk);
            if (rdy_mode == 1)      ready = ~ready;
            else if (rdy_mode == 2) ready = 1'b1;
            else                    ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples just before each rising edge and scores the beat about to happen
    initial begin
        logic [NL-1:0] prev_sel;
        bit            prev_stall;
        bit            fe_pend;
        logic [1:0]    done_pend;
        beat_t         e;
        prev_sel = '0;
        prev_stall = 1'b0;
        fe_pend = 1'b0;
        done_pend = 2'b00;
        forever begin
            @(negedge clk);
            #4;
            if (rst || !mon_en) begin
                prev_stall = 1'b0;
                fe_pend    = 1'b0;
                done_pend  = 2'b00;
                continue;
            end
            if (fe_pend || frame_end) chk("frame_end", frame_end, fe_pend);
            if (done_pend != 0 || bank_done != 0) chk("bank_done", bank_done, done_pend);
            fe_pend   = 1'b0;
            done_pend = 2'b00;
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_sel", line_sel, prev_sel);
            end
            prev_stall = 1'b0;
            if (m_valid) begin
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: sel %0h but no beat expected", line_sel);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_sel", line_sel, onehot(e.line));
                        chk("beat_last", m_last, e.last);
                        chk("beat_sof", m_sof, e.sof);
                        chk("beat_rd_en", line_rd_en, onehot(e.line));
                        fe_pend   = e.fe;
                        done_pend = e.done ? (2'b01 << e.bank) : 2'b00;
                    end
                end else begin
                    chk("stall_rd_en", line_rd_en, 0);
                    prev_stall = 1'b1;
                    prev_sel   = line_sel;
                end
            end else begin
                chk("idle_marks", {m_last, m_sof, |line_rd_en}, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, first, second, nd, got, cyc, hold;
        rst        = 1'b1;
        bank_full  = 2'b00;
        line_empty = '0;
        sof_pulse  = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_sel", line_sel, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_marks", {m_last, m_sof, frame_end, bank_done, underflow}, 0);
        chk("rst_rd_en", line_rd_en, 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int ep = 0; ep < NEP; ep++) begin
            rdy_mode = (ep % 4 == 3) ? 1 : 0;
            m = (ep == 0) ? 3 : $urandom_range(1, 3);
            if (ep == 0 || $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                sof_pulse = 1'b1;
                model_sof();
                @(negedge clk);
                sof_pulse = 1'b0;
                @(negedge clk);
            end
            if (m == 3) begin
                first  = (last_bank_m == 1) ? 0 : 1;
                second = 1 - first;
                push_bank(first);
                push_bank(second);
                last_bank_m = second;
                nd = 2;
            end else begin
                first = (m == 2) ? 1 : 0;
                push_bank(first);
                last_bank_m = first;
                nd = 1;
            end
            chk("idle_sel", line_sel, 0);
            bank_full = m[1:0];
            @(posedge clk);
            #1;
            chk("grant_sel", line_sel, onehot(first * L));

            got = 0;
            cyc = 0;
            while (got < nd && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                if (|bank_done) got++;
            end
            if (got < nd) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got %0d bank_done pulses expected %0d", got, nd);
            end
            hold = (ep % 3 == 0) ? 3 : $urandom_range(0, 3);
            repeat (hold) begin
                @(negedge clk);
                chk("no_regrant", line_sel, 0);
            end
            bank_full = 2'b00;
            repeat (2) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("no_underflow", underflow, 0);

        // Underflow and mid-line reset on bank 0
        mon_en    = 1'b0;
        rdy_mode  = 2;
        bank_full = 2'b01;
        repeat (4) @(negedge clk);
        chk("uf_pre_valid", m_valid, 1);
        chk("uf_pre_sel", line_sel, onehot(0));
        line_empty = onehot(0);
        #1;
        chk("uf_valid_drop", m_valid, 0);
        chk("uf_rd_en", line_rd_en, 0);
        @(posedge clk);
        #1;
        chk("uf_set", underflow, 1);
        @(negedge clk);
        line_empty = '0;
        repeat (3) @(negedge clk);
        chk("uf_sticky", underflow, 1);
        chk("uf_valid_back", m_valid, 1);
        rst       = 1'b1;
        bank_full = 2'b00;
        @(posedge clk);
        #1;
        chk("rst_mid_sel", line_sel, 0);
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_marks", {m_last, m_sof, frame_end, bank_done, underflow}, 0);
        chk("rst_mid_rd_en", line_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
